mem_port_arbiter: RTL and testbench

- Arbitrates a single-port unified memory between the instruction-fetch unit (IF) and the load/store path (DM).
- The DM path is driven by the MemRead/MemWrite decode outputs.
- Sequences each access as a request/acknowledge transaction, returns read data to the owning requester and signals completion.
- Sits between the core (fetch stage, memory stage) and the memory model; the core stalls on the absence of done pulses.

---
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/ack bundle between the core's fetch and memory stages, the arbiter and the memory model.
// The arbiter uses the slave view; the core/memory side uses the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_done;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
        output if_gnt, if_done, if_rdata, if_err, dm_gnt, dm_done, dm_rdata, dm_err,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
        input  if_gnt, if_done, if_rdata, if_err, dm_gnt, dm_done, dm_rdata, dm_err,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and load/store (DM).
// state  | meaning
// IDLE   | no access in flight; requests evaluated at each edge
// BUSY   | one access owned by IF or DM; waiting for mem_ack or timeout
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t            state_q;
    logic              owner_dm_q;
    logic [SW-1:0]     streak_q;
    logic [TW-1:0]     tmo_q;

    logic              if_gnt_q, if_done_q, if_err_q;
    logic              dm_gnt_q, dm_done_q, dm_err_q;
    logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              pick_if_d, pick_dm_d, tmo_hit_d;
    logic [SW-1:0]     streak_d;

    always_comb begin
        pick_if_d = bus.if_req && (!bus.dm_req || streak_q == SW'(STARVE_MAX));
        pick_dm_d = bus.dm_req && !pick_if_d;
        tmo_hit_d = (tmo_q == TW'(TIMEOUT_CYC - 1));
        streak_d  = streak_q;
        if (pick_if_d) begin
            streak_d = '0;
        end else if (pick_dm_d) begin
            // only a contested DM win counts toward starving IF
            if (!bus.if_req)
                streak_d = '0;
            else if (streak_q != SW'(STARVE_MAX))
                streak_d = streak_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            owner_dm_q  <= 1'b1;
            streak_q    <= '0;
            tmo_q       <= '0;
            if_gnt_q    <= 1'b0;
            if_done_q   <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_gnt_q    <= 1'b0;
            dm_done_q   <= 1'b0;
            dm_err_q    <= 1'b0;
            dm_rdata_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if_gnt_q  <= 1'b0;
            dm_gnt_q  <= 1'b0;
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_if_d || pick_dm_d) begin
                        state_q     <= S_BUSY;
                        mem_req_q   <= 1'b1;
                        owner_dm_q  <= pick_dm_d;
                        mem_we_q    <= pick_dm_d && bus.dm_we;
                        mem_addr_q  <= pick_dm_d ? bus.dm_addr : bus.if_addr;
                        mem_wdata_q <= pick_dm_d ? bus.dm_wdata : '0;
                        tmo_q       <= '0;
                        if_gnt_q    <= pick_if_d;
                        dm_gnt_q    <= pick_dm_d;
                        streak_q    <= streak_d;
                    end
                end
                S_BUSY: begin
                    // ack takes precedence over a timeout in the same cycle
                    if (bus.mem_ack) begin
                        state_q   <= S_IDLE;
                        mem_req_q <= 1'b0;
                        if (owner_dm_q) begin
                            dm_done_q <= 1'b1;
                            dm_err_q  <= 1'b0;
                            if (!mem_we_q)
                                dm_rdata_q <= bus.mem_rdata;
                        end else begin
                            if_done_q  <= 1'b1;
                            if_err_q   <= 1'b0;
                            if_rdata_q <= bus.mem_rdata;
                        end
                    end else if (tmo_hit_d) begin
                        state_q   <= S_IDLE;
                        mem_req_q <= 1'b0;
                        if (owner_dm_q) begin
                            dm_done_q <= 1'b1;
                            dm_err_q  <= 1'b1;
                        end else begin
                            if_done_q <= 1'b1;
                            if_err_q  <= 1'b1;
                        end
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_err    = if_err_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_gnt    = dm_gnt_q;
    assign bus.dm_done   = dm_done_q;
    assign bus.dm_err    = dm_err_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single transactions plus
// contention, starvation, timeout and mid-transaction reset sequences.
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;
    localparam int TMO  = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        ifr;
        logic        dmr;
        logic        we;
        logic [31:0] if_addr;
        logic [31:0] dm_addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        int          dly;
        logic        exp_if_gnt;
        logic        exp_dm_gnt;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_dm_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = '0;
        bus.dm_wdata  = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic run_vec(input int k, input vec_t v);
        bus.if_req   = v.ifr;
        bus.dm_req   = v.dmr;
        bus.dm_we    = v.we;
        bus.if_addr  = v.if_addr;
        bus.dm_addr  = v.dm_addr;
        bus.dm_wdata = v.wdata;
        tick();
        chk($sformatf("v%0d if_gnt", k), bus.if_gnt, v.exp_if_gnt);
        chk($sformatf("v%0d dm_gnt", k), bus.dm_gnt, v.exp_dm_gnt);
        chk($sformatf("v%0d mem_req", k), bus.mem_req, 1);
        chk($sformatf("v%0d mem_we", k), bus.mem_we, v.exp_we);
        chk($sformatf("v%0d mem_addr", k), bus.mem_addr, v.exp_addr);
        chk($sformatf("v%0d mem_wdata", k), bus.mem_wdata, v.exp_wdata);
        bus.if_req   = 1'b0;
        bus.dm_req   = 1'b0;
        bus.dm_addr  = 32'hFFFF_0000;
        bus.dm_wdata = 32'hFFFF_FFFF;
        bus.if_addr  = 32'hFFFF_1111;
        for (int d = 0; d < v.dly; d++) begin
            tick();
            chk($sformatf("v%0d busy%0d mem_req", k, d), bus.mem_req, 1);
            chk($sformatf("v%0d busy%0d done", k, d), {bus.if_done, bus.dm_done}, 0);
            chk($sformatf("v%0d busy%0d addr", k, d), bus.mem_addr, v.exp_addr);
            chk($sformatf("v%0d busy%0d we", k, d), bus.mem_we, v.exp_we);
            chk($sformatf("v%0d busy%0d wdata", k, d), bus.mem_wdata, v.exp_wdata);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = v.mrdata;
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h5A5A_5A5A;
        chk($sformatf("v%0d if_done", k), bus.if_done, v.exp_if_gnt);
        chk($sformatf("v%0d dm_done", k), bus.dm_done, v.exp_dm_gnt);
        chk($sformatf("v%0d err", k), {bus.if_err, bus.dm_err}, 0);
        chk($sformatf("v%0d mem_req_off", k), bus.mem_req, 0);
        chk($sformatf("v%0d if_rdata", k), bus.if_rdata, v.exp_if_rdata);
        chk($sformatf("v%0d dm_rdata", k), bus.dm_rdata, v.exp_dm_rdata);
        tick();
        chk($sformatf("v%0d single_done", k), {bus.if_done, bus.dm_done}, 0);
    endtask

    // Both requesters held: expect n_dm DM grants, then IF forced through.
    task automatic contested(input int n_dm, input string tag);
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h40;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 32'h500;
        bus.dm_wdata = 32'hA5;
        for (int i = 0; i <= n_dm; i++) begin
            tick();
            chk($sformatf("%s g%0d dm_gnt", tag, i), bus.dm_gnt, (i < n_dm));
            chk($sformatf("%s g%0d if_gnt", tag, i), bus.if_gnt, (i == n_dm));
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'h1000 + i;
            tick();
            bus.mem_ack   = 1'b0;
            chk($sformatf("%s g%0d done", tag, i), {bus.if_done, bus.dm_done},
                (i < n_dm) ? 32'd1 : 32'd2);
        end
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
    endtask

    initial begin
        //          ifr  dmr  we   if_addr  dm_addr   wdata         mrdata        dly eif edm ewe eaddr     ewdata        e_if_rdata    e_dm_rdata
        vecs[0] = '{1'b0,1'b1,1'b0,32'h0,   32'h100,  32'h0,        32'hDEADBEEF, 0, 1'b0,1'b1,1'b0,32'h100, 32'h0,        32'h0,        32'hDEADBEEF};
        vecs[1] = '{1'b1,1'b0,1'b0,32'h4,   32'h0,    32'h0,        32'h11112222, 1, 1'b1,1'b0,1'b0,32'h4,   32'h0,        32'h11112222, 32'hDEADBEEF};
        vecs[2] = '{1'b0,1'b1,1'b1,32'h0,   32'h300,  32'hCAFEF00D, 32'h99999999, 5, 1'b0,1'b1,1'b1,32'h300, 32'hCAFEF00D, 32'h11112222, 32'hDEADBEEF};
        vecs[3] = '{1'b0,1'b1,1'b0,32'h0,   32'h104,  32'h0,        32'h0BADC0DE, 2, 1'b0,1'b1,1'b0,32'h104, 32'h0,        32'h11112222, 32'h0BADC0DE};
        vecs[4] = '{1'b1,1'b0,1'b0,32'h8,   32'h0,    32'h0,        32'h33334444, 0, 1'b1,1'b0,1'b0,32'h8,   32'h0,        32'h33334444, 32'h0BADC0DE};

        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        chk("rst mem_req", bus.mem_req, 0);
        chk("rst gnt", {bus.if_gnt, bus.dm_gnt}, 0);
        chk("rst done", {bus.if_done, bus.dm_done}, 0);
        chk("rst rdata", bus.dm_rdata | bus.if_rdata, 0);
        reset = 1'b1;
        tick();

        for (int k = 0; k < 5; k++) run_vec(k, vecs[k]);

        // contention: DM store first, IF after dm_done plus one idle cycle
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h80;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 32'h200;
        bus.dm_wdata = 32'h55;
        tick();
        chk("cont dm_gnt", bus.dm_gnt, 1);
        chk("cont if_gnt", bus.if_gnt, 0);
        chk("cont mem_we", bus.mem_we, 1);
        chk("cont mem_addr", bus.mem_addr, 32'h200);
        chk("cont mem_wdata", bus.mem_wdata, 32'h55);
        bus.dm_req  = 1'b0;
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("cont dm_done", bus.dm_done, 1);
        chk("cont if_gnt_early", bus.if_gnt, 0);
        tick();
        chk("cont if_gnt", bus.if_gnt, 1);
        chk("cont if_addr", bus.mem_addr, 32'h80);
        chk("cont if_we", bus.mem_we, 0);
        bus.if_req    = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h77;
        tick();
        bus.mem_ack = 1'b0;
        chk("cont if_done", bus.if_done, 1);
        chk("cont if_rdata", bus.if_rdata, 32'h77);
        tick();

        // starvation, then the streak restarts after the forced IF grant
        contested(SMAX, "starve");
        contested(SMAX, "restart");
        tick();

        // timeout: no ack ever, done+err exactly TMO cycles after mem_req rises
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h400;
        tick();
        chk("tmo dm_gnt", bus.dm_gnt, 1);
        chk("tmo mem_req", bus.mem_req, 1);
        bus.dm_req = 1'b0;
        for (int c = 1; c < TMO; c++) begin
            tick();
            chk($sformatf("tmo c%0d pending", c), {bus.mem_req, bus.dm_done}, 32'd2);
        end
        tick();
        chk("tmo dm_done", bus.dm_done, 1);
        chk("tmo dm_err", bus.dm_err, 1);
        chk("tmo mem_req", bus.mem_req, 0);
        chk("tmo dm_rdata", bus.dm_rdata, 32'h0BADC0DE);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hBAD0BAD0;
        tick();
        bus.mem_ack = 1'b0;
        chk("late ack done", {bus.if_done, bus.dm_done}, 0);
        chk("late ack mem_req", bus.mem_req, 0);
        chk("late ack rdata", bus.dm_rdata, 32'h0BADC0DE);
        tick();
        chk("late ack quiet", {bus.if_done, bus.dm_done, bus.if_gnt, bus.dm_gnt}, 0);

        // reset mid-transaction with a nonzero streak
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h40;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 32'h600;
        bus.dm_wdata = 32'h66;
        for (int i = 0; i < 2; i++) begin
            tick();
            bus.mem_ack = 1'b1;
            tick();
            bus.mem_ack = 1'b0;
        end
        tick();
        chk("mid dm_gnt", bus.dm_gnt, 1);
        tick();
        reset = 1'b0;
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        tick();
        chk("mid mem_req", bus.mem_req, 0);
        chk("mid gnt", {bus.if_gnt, bus.dm_gnt}, 0);
        chk("mid done", {bus.if_done, bus.dm_done}, 0);
        chk("mid err", {bus.if_err, bus.dm_err}, 0);
        reset = 1'b1;
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("post rst no done", {bus.if_done, bus.dm_done}, 0);
        tick();
        chk("post rst idle", {bus.mem_req, bus.if_done, bus.dm_done}, 0);
        contested(SMAX, "postrst");
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
